frame_swap_buffer: RTL and testbench

Double-buffered 256x256x8 pixel store between the core's pixel writer (`hh`/`vv`/colour/`color_ready`/`frame`) and the video timing generator. Core writes land in the back bank. The scan-out path reads the front bank with a fixed pipeline latency and delays the sync signals to match. The banks swap only at a vertical-sync edge, and only after the core has signalled a completed frame, so scan-out never tears. Status counters report swaps and frame overruns.

---
 rtl/frame_swap_buffer_if.sv | 39 +++
 rtl/frame_swap_buffer.sv | 155 +++++++++++++++
 tb/tb_frame_swap_buffer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/frame_swap_buffer_if.sv
// Pixel-writer, scan-timing and status signals of the double-buffered frame store.
// The slave modport is the buffer; the master modport is the core/timing side.
interface frame_swap_buffer_if;
    logic       pix_ce;
    logic       wr_en;
    logic [7:0] wr_x;
    logic [7:0] wr_y;
    logic [7:0] wr_data;
    logic       frame;
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic       de_in;
    logic       hs_in;
    logic       vs_in;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       de_out;
    logic       hs_out;
    logic       vs_out;
    logic       front_bank;
    logic       swap_pending;
    logic [15:0] swap_cnt;
    logic [7:0] overrun_cnt;

    modport slave (
        input  pix_ce, wr_en, wr_x, wr_y, wr_data, frame,
        input  hcount, vcount, de_in, hs_in, vs_in,
        output vga_r, vga_g, vga_b, de_out, hs_out, vs_out,
        output front_bank, swap_pending, swap_cnt, overrun_cnt
    );

    modport master (
        output pix_ce, wr_en, wr_x, wr_y, wr_data, frame,
        output hcount, vcount, de_in, hs_in, vs_in,
        input  vga_r, vga_g, vga_b, de_out, hs_out, vs_out,
        input  front_bank, swap_pending, swap_cnt, overrun_cnt
    );
endinterface

// File: rtl/frame_swap_buffer.sv
// Double-buffered 256x256x8 frame store: core writes the back bank, scan-out reads
// the front bank through a 3-stage pix_ce pipeline; banks swap only on vsync after a completed frame.
module frame_swap_buffer (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    frame_swap_buffer_if.slave    bus
);

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

    state_t      state;
    logic        frame_prev;
    logic        vs_prev;
    logic        front_bank;
    logic        swap_pending;
    logic [15:0] swap_cnt;
    logic [7:0]  overrun_cnt;
    logic        frame_edge;
    logic        vs_edge;

    logic [7:0]  mem [0:131071];

    logic        in_win_p0, de_p0, hs_p0, vs_p0;
    logic [16:0] addr_p0;
    logic        in_win_p1, de_p1, hs_p1, vs_p1;
    logic [7:0]  rd_p1;
    logic [7:0]  r_p2, g_p2, b_p2;
    logic        de_p2, hs_p2, vs_p2;

    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    function automatic logic [7:0] expand2(input logic [1:0] c);
        return {c, c, c, c};
    endfunction

    assign frame_edge = bus.frame & ~frame_prev;
    assign vs_edge    = bus.vs_in & ~vs_prev;

    // Swap control: a completed frame waits for vsync so scan-out never tears
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            frame_prev   <= 1'b0;
            vs_prev      <= 1'b0;
            front_bank   <= 1'b0;
            swap_pending <= 1'b0;
            swap_cnt     <= 16'd0;
            overrun_cnt  <= 8'd0;
        end else begin
            frame_prev <= bus.frame;
            vs_prev    <= bus.vs_in;
            case (state)
                IDLE: begin
                    if (frame_edge && vs_edge) begin
                        front_bank <= ~front_bank;
                        swap_cnt   <= swap_cnt + 16'd1;
                    end else if (frame_edge) begin
                        state        <= PENDING;
                        swap_pending <= 1'b1;
                    end
                end
                PENDING: begin
                    if (vs_edge) begin
                        front_bank   <= ~front_bank;
                        swap_cnt     <= swap_cnt + 16'd1;
                        state        <= IDLE;
                        swap_pending <= 1'b0;
                    end else if (frame_edge && overrun_cnt != 8'hFF) begin
                        overrun_cnt <= overrun_cnt + 8'd1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    swap_pending <= 1'b0;
                end
            endcase
        end
    end

    // Write port targets the bank not being scanned, using the pre-toggle front_bank
    always_ff @(posedge clk_sys) begin
        if (bus.wr_en)
            mem[{~front_bank, bus.wr_y, bus.wr_x}] <= bus.wr_data;
    end

    // Stage 0: window test, read address, sync capture
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            in_win_p0 <= 1'b0;
            addr_p0   <= 17'd0;
            de_p0     <= 1'b0;
            hs_p0     <= 1'b0;
            vs_p0     <= 1'b0;
        end else if (bus.pix_ce) begin
            in_win_p0 <= bus.de_in & ~bus.hcount[8] & ~bus.vcount[8];
            addr_p0   <= {front_bank, bus.vcount[7:0], bus.hcount[7:0]};
            de_p0     <= bus.de_in;
            hs_p0     <= bus.hs_in;
            vs_p0     <= bus.vs_in;
        end
    end

    // Stage 1: synchronous RAM read (data register left unreset so it maps onto block RAM)
    always_ff @(posedge clk_sys) begin
        if (bus.pix_ce)
            rd_p1 <= mem[addr_p0];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            in_win_p1 <= 1'b0;
            de_p1     <= 1'b0;
            hs_p1     <= 1'b0;
            vs_p1     <= 1'b0;
        end else if (bus.pix_ce) begin
            in_win_p1 <= in_win_p0;
            de_p1     <= de_p0;
            hs_p1     <= hs_p0;
            vs_p1     <= vs_p0;
        end
    end

    // Stage 2: colour expansion and blanking outside the 256x256 window
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_p2  <= 8'd0;
            g_p2  <= 8'd0;
            b_p2  <= 8'd0;
            de_p2 <= 1'b0;
            hs_p2 <= 1'b0;
            vs_p2 <= 1'b0;
        end else if (bus.pix_ce) begin
            r_p2  <= in_win_p1 ? expand3(rd_p1[7:5]) : 8'd0;
            g_p2  <= in_win_p1 ? expand3(rd_p1[4:2]) : 8'd0;
            b_p2  <= in_win_p1 ? expand2(rd_p1[1:0]) : 8'd0;
            de_p2 <= de_p1;
            hs_p2 <= hs_p1;
            vs_p2 <= vs_p1;
        end
    end

    assign bus.vga_r        = r_p2;
    assign bus.vga_g        = g_p2;
    assign bus.vga_b        = b_p2;
    assign bus.de_out       = de_p2;
    assign bus.hs_out       = hs_p2;
    assign bus.vs_out       = vs_p2;
    assign bus.front_bank   = front_bank;
    assign bus.swap_pending = swap_pending;
    assign bus.swap_cnt     = swap_cnt;
    assign bus.overrun_cnt  = overrun_cnt;

endmodule

// File: tb/tb_frame_swap_buffer.sv
// Directed bench for frame_swap_buffer: reset, write/scan-out, window blanking,
// no-tear, overrun saturation, simultaneous events and reset while pending.
module tb_frame_swap_buffer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    frame_swap_buffer_if bus ();

    frame_swap_buffer dut (
        .clk_sys (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_px(input logic [7:0] x, input logic [7:0] y, input logic [7:0] d);
        bus.wr_x = x; bus.wr_y = y; bus.wr_data = d; bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_frame();
        bus.frame = 1'b1; tick(); tick();
        bus.frame = 1'b0; tick();
    endtask

    task automatic pulse_vs();
        bus.vs_in = 1'b1; tick(); tick();
        bus.vs_in = 1'b0; tick();
    endtask

    task automatic scan(input logic [8:0] h, input logic [8:0] v, input logic de,
                        input logic hs, input logic vs);
        bus.hcount = h; bus.vcount = v; bus.de_in = de; bus.hs_in = hs; bus.vs_in = vs;
        bus.pix_ce = 1'b1;
        repeat (3) tick();
        bus.pix_ce = 1'b0;
        bus.hs_in = 1'b0; bus.vs_in = 1'b0; bus.de_in = 1'b0;
        tick();
    endtask

    initial begin
        bus.pix_ce = 0; bus.wr_en = 0; bus.wr_x = 0; bus.wr_y = 0; bus.wr_data = 0;
        bus.frame = 0; bus.hcount = 0; bus.vcount = 0; bus.de_in = 0; bus.hs_in = 0; bus.vs_in = 0;

        // reset held while inputs toggle
        for (int i = 0; i < 6; i++) begin
            bus.pix_ce = i[0]; bus.frame = ~i[0]; bus.vs_in = i[1]; bus.hs_in = i[0];
            bus.de_in = 1'b1; bus.hcount = 9'(i); bus.vcount = 9'(i);
            tick();
        end
        bus.pix_ce = 0; bus.frame = 0; bus.vs_in = 0; bus.hs_in = 0; bus.de_in = 0;
        bus.hcount = 0; bus.vcount = 0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_vga_r", 16'(bus.vga_r), 16'h0);
        chk("rst_vga_g", 16'(bus.vga_g), 16'h0);
        chk("rst_vga_b", 16'(bus.vga_b), 16'h0);
        chk("rst_sync", 16'({bus.de_out, bus.hs_out, bus.vs_out}), 16'h0);
        chk("rst_front", 16'(bus.front_bank), 16'h0);
        chk("rst_pending", 16'(bus.swap_pending), 16'h0);
        chk("rst_swap_cnt", bus.swap_cnt, 16'h0);
        chk("rst_overrun", 16'(bus.overrun_cnt), 16'h0);

        // write into back bank 1, complete frame, swap on vsync
        write_px(8'd5, 8'd3, 8'hE0);
        write_px(8'd6, 8'd3, 8'h1D);
        pulse_frame();
        chk("pend_after_frame", 16'(bus.swap_pending), 16'h1);
        chk("front_before_vs", 16'(bus.front_bank), 16'h0);
        pulse_vs();
        chk("front_after_vs", 16'(bus.front_bank), 16'h1);
        chk("swap_cnt_1", bus.swap_cnt, 16'd1);
        chk("pend_cleared", 16'(bus.swap_pending), 16'h0);

        scan(9'd5, 9'd3, 1'b1, 1'b0, 1'b0);
        chk("px53_r", 16'(bus.vga_r), 16'hFF);
        chk("px53_g", 16'(bus.vga_g), 16'h00);
        chk("px53_b", 16'(bus.vga_b), 16'h00);
        chk("px53_de", 16'(bus.de_out), 16'h1);
        scan(9'd6, 9'd3, 1'b1, 1'b1, 1'b0);
        chk("px63_r", 16'(bus.vga_r), 16'h00);
        chk("px63_g", 16'(bus.vga_g), 16'hFF);
        chk("px63_b", 16'(bus.vga_b), 16'h55);
        chk("px63_hs", 16'(bus.hs_out), 16'h1);

        // outputs hold while pix_ce is low
        bus.hcount = 9'd5; bus.de_in = 1'b0;
        repeat (3) tick();
        chk("hold_g", 16'(bus.vga_g), 16'hFF);

        // window blanking
        scan(9'd300, 9'd3, 1'b1, 1'b0, 1'b0);
        chk("win_h_rgb", 16'({bus.vga_r, bus.vga_g} | 16'(bus.vga_b)), 16'h0);
        chk("win_h_de", 16'(bus.de_out), 16'h1);
        scan(9'd5, 9'd300, 1'b1, 1'b0, 1'b0);
        chk("win_v_rgb", 16'({bus.vga_r, bus.vga_g} | 16'(bus.vga_b)), 16'h0);
        scan(9'd5, 9'd3, 1'b0, 1'b0, 1'b0);
        chk("de0_rgb", 16'({bus.vga_r, bus.vga_g} | 16'(bus.vga_b)), 16'h0);
        chk("de0_de", 16'(bus.de_out), 16'h0);

        // no-tear: back bank 0 written, vsyncs without frame edge
        write_px(8'd5, 8'd3, 8'h03);
        pulse_vs();
        pulse_vs();
        chk("notear_front", 16'(bus.front_bank), 16'h1);
        chk("notear_cnt", bus.swap_cnt, 16'd1);
        scan(9'd5, 9'd3, 1'b1, 1'b0, 1'b1);
        chk("notear_r", 16'(bus.vga_r), 16'hFF);
        chk("notear_b", 16'(bus.vga_b), 16'h00);
        chk("vs_out", 16'(bus.vs_out), 16'h1);
        chk("notear_front2", 16'(bus.front_bank), 16'h1);

        // swap to bank 0 shows new data
        pulse_frame();
        pulse_vs();
        chk("swap2_front", 16'(bus.front_bank), 16'h0);
        chk("swap2_cnt", bus.swap_cnt, 16'd2);
        scan(9'd5, 9'd3, 1'b1, 1'b0, 1'b0);
        chk("swap2_r", 16'(bus.vga_r), 16'h00);
        chk("swap2_b", 16'(bus.vga_b), 16'hFF);

        // overrun
        pulse_frame(); pulse_frame(); pulse_frame();
        chk("ovr_cnt2", 16'(bus.overrun_cnt), 16'd2);
        chk("ovr_pending", 16'(bus.swap_pending), 16'h1);
        pulse_vs();
        chk("ovr_swap_front", 16'(bus.front_bank), 16'h1);
        chk("ovr_swap_cnt", bus.swap_cnt, 16'd3);
        chk("ovr_pend_clr", 16'(bus.swap_pending), 16'h0);

        // simultaneous frame+vsync+write from IDLE: write lands in old back bank 0
        bus.wr_x = 8'd9; bus.wr_y = 8'd9; bus.wr_data = 8'hE0; bus.wr_en = 1'b1;
        bus.frame = 1'b1; bus.vs_in = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        chk("sim_front", 16'(bus.front_bank), 16'h0);
        chk("sim_cnt", bus.swap_cnt, 16'd4);
        chk("sim_pending", 16'(bus.swap_pending), 16'h0);
        bus.frame = 1'b0; bus.vs_in = 1'b0;
        tick();
        scan(9'd9, 9'd9, 1'b1, 1'b0, 1'b0);
        chk("sim_wr_r", 16'(bus.vga_r), 16'hFF);

        // overrun saturation
        for (int i = 0; i < 300; i++) pulse_frame();
        chk("ovr_sat", 16'(bus.overrun_cnt), 16'd255);
        chk("ovr_sat_pend", 16'(bus.swap_pending), 16'h1);
        pulse_vs();
        chk("sat_swap_cnt", bus.swap_cnt, 16'd5);
        chk("sat_front", 16'(bus.front_bank), 16'h1);

        // reset while pending drops the swap
        pulse_frame();
        chk("pre_rst_pend", 16'(bus.swap_pending), 16'h1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("mid_rst_pend", 16'(bus.swap_pending), 16'h0);
        chk("mid_rst_front", 16'(bus.front_bank), 16'h0);
        chk("mid_rst_ovr", 16'(bus.overrun_cnt), 16'h0);
        chk("mid_rst_r", 16'(bus.vga_r), 16'h0);
        pulse_vs();
        chk("no_swap_front", 16'(bus.front_bank), 16'h0);
        chk("no_swap_cnt", bus.swap_cnt, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
